// File: rtl/csc_pkg.sv
// Colour-space conversion constants: mode encoding, Q14 coefficient magnitudes and a rescaler
// for other fractional widths.
package csc_pkg;

  typedef enum logic [1:0] {
    MODE_601  = 2'd0,
    MODE_PASS = 2'd1,
    MODE_709  = 2'd2,
    MODE_RSVD = 2'd3
  } csc_mode_e;

  localparam int COEF_FRAC_REF = 14;

  // Magnitudes ordered Y(R,G,B), Cb(R,G,B), Cr(R,G,B); each channel's MAC owns the signs.
  localparam int BT601_K [0:8] = '{4899, 9617, 1868, 2764, 5428, 8192, 8192, 6860, 1332};
  localparam int BT709_K [0:8] = '{3483, 11718, 1183, 1877, 6315, 8192, 8192, 7441, 751};

  function automatic int csc_scale(input int coef, input int frac_w);
    if (frac_w >= COEF_FRAC_REF)
      return coef <<< (frac_w - COEF_FRAC_REF);
    return (coef + (1 <<< (COEF_FRAC_REF - frac_w - 1))) >>> (COEF_FRAC_REF - frac_w);
  endfunction

endpackage

// File: rtl/csc_mac.sv
// One output channel of the converter: S1 unsigned products, S2 signed sum + half-LSB, S3 shift/offset/clamp.
// Three register stages, all gated by the shared i_adv stall; passthrough component rides alongside.
module csc_mac
  import csc_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int FRAC_W    = 14,
  parameter bit NEG0      = 1'b0,
  parameter bit NEG1      = 1'b0,
  parameter bit NEG2      = 1'b0,
  parameter bit OFFSET_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic [PIX_W-1:0]  i_x0,
  input  logic [PIX_W-1:0]  i_x1,
  input  logic [PIX_W-1:0]  i_x2,
  input  logic [FRAC_W:0]   i_k0,
  input  logic [FRAC_W:0]   i_k1,
  input  logic [FRAC_W:0]   i_k2,
  input  logic [PIX_W-1:0]  i_raw,
  input  logic              i_pass,
  output logic [PIX_W-1:0]  o_dat
);

  localparam int PRW = PIX_W + FRAC_W + 1;
  localparam int SW  = 2*PIX_W + FRAC_W + 2;

  localparam logic signed [SW-1:0] RND  = {{(SW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [SW-1:0] HALF = {{(SW-PIX_W){1'b0}}, 1'b1, {(PIX_W-1){1'b0}}};
  localparam logic signed [SW-1:0] OFFS = OFFSET_EN ? HALF : '0;
  localparam logic signed [SW-1:0] MAXV = {{(SW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic        [PRW-1:0]   r_p0, r_p1, r_p2;
  logic        [PIX_W-1:0] r_raw_s1, r_raw_s2;
  logic signed [SW-1:0]    r_sum;
  logic        [PIX_W-1:0] r_dat;

  logic signed [SW-1:0]    w_t0, w_t1, w_t2, w_sum, w_val;
  logic        [PIX_W-1:0] w_clamp;

  assign w_t0  = $signed(SW'(r_p0));
  assign w_t1  = $signed(SW'(r_p1));
  assign w_t2  = $signed(SW'(r_p2));
  assign w_sum = (NEG0 ? -w_t0 : w_t0) + (NEG1 ? -w_t1 : w_t1) + (NEG2 ? -w_t2 : w_t2) + RND;

  // Arithmetic shift floors negative sums, so the half-LSB added in S2 gives round-half-up.
  assign w_val = (r_sum >>> FRAC_W) + OFFS;

  always_comb begin
    w_clamp = w_val[PIX_W-1:0];
    if (w_val[SW-1])
      w_clamp = '0;
    else if (w_val > MAXV)
      w_clamp = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_raw_s1 <= '0;
      r_raw_s2 <= '0;
      r_sum    <= '0;
      r_dat    <= '0;
    end else if (i_adv) begin
      r_p0     <= PRW'(i_x0) * PRW'(i_k0);
      r_p1     <= PRW'(i_x1) * PRW'(i_k1);
      r_p2     <= PRW'(i_x2) * PRW'(i_k2);
      r_raw_s1 <= i_raw;
      r_sum    <= w_sum;
      r_raw_s2 <= r_raw_s1;
      r_dat    <= i_pass ? r_raw_s2 : w_clamp;
    end
  end

  assign o_dat = r_dat;

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// RGB -> YCbCr (BT.601, passthrough, BT.709 when RGB2YCBCR_BT709_EN is defined), 3-cycle latency, 1 px/clk.
// Whole pipeline stalls only while the output stage holds a pixel the sink has not taken.
module rgb2ycbcr_pipe
  import csc_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*PIX_W-1:0]   in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*PIX_W-1:0]   out_data
);

  localparam int CW = FRAC_W + 1;

  logic            w_adv;
  logic            w_pass;
  logic [PIX_W-1:0] w_r, w_g, w_b;
  logic [CW-1:0]   w_k [0:8];

  logic            r_vld_s1, r_vld_s2, r_vld_s3;
  csc_mode_e       r_mode_s1, r_mode_s2;

  assign w_adv    = ~r_vld_s3 | out_ready;
  assign in_ready = w_adv;

  assign w_r = in_data[PIX_W-1:0];
  assign w_g = in_data[2*PIX_W-1:PIX_W];
  assign w_b = in_data[3*PIX_W-1:2*PIX_W];

  // Coefficients are picked from the incoming mode, so a mode switch lands on its own pixel.
  for (genvar gi = 0; gi < 9; gi++) begin : g_coef
    localparam logic [CW-1:0] C601 = CW'(csc_scale(BT601_K[gi], FRAC_W));
`ifdef RGB2YCBCR_BT709_EN
    localparam logic [CW-1:0] C709 = CW'(csc_scale(BT709_K[gi], FRAC_W));
    assign w_k[gi] = (in_mode == MODE_709) ? C709 : C601;
`else
    assign w_k[gi] = C601;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_s1  <= 1'b0;
      r_vld_s2  <= 1'b0;
      r_vld_s3  <= 1'b0;
      r_mode_s1 <= MODE_601;
      r_mode_s2 <= MODE_601;
    end else if (w_adv) begin
      r_vld_s1  <= in_valid;
      r_vld_s2  <= r_vld_s1;
      r_vld_s3  <= r_vld_s2;
      r_mode_s1 <= csc_mode_e'(in_mode);
      r_mode_s2 <= r_mode_s1;
    end
  end

  assign w_pass    = (r_mode_s2 == MODE_PASS);
  assign out_valid = r_vld_s3;

  csc_mac #(
    .PIX_W(PIX_W), .FRAC_W(FRAC_W),
    .NEG0(1'b0), .NEG1(1'b0), .NEG2(1'b0), .OFFSET_EN(1'b0)
  ) u_mac_y (
    .clk(clk), .rst_n(rst_n), .i_adv(w_adv),
    .i_x0(w_r), .i_x1(w_g), .i_x2(w_b),
    .i_k0(w_k[0]), .i_k1(w_k[1]), .i_k2(w_k[2]),
    .i_raw(w_r), .i_pass(w_pass),
    .o_dat(out_data[PIX_W-1:0])
  );

  csc_mac #(
    .PIX_W(PIX_W), .FRAC_W(FRAC_W),
    .NEG0(1'b1), .NEG1(1'b1), .NEG2(1'b0), .OFFSET_EN(1'b1)
  ) u_mac_cb (
    .clk(clk), .rst_n(rst_n), .i_adv(w_adv),
    .i_x0(w_r), .i_x1(w_g), .i_x2(w_b),
    .i_k0(w_k[3]), .i_k1(w_k[4]), .i_k2(w_k[5]),
    .i_raw(w_g), .i_pass(w_pass),
    .o_dat(out_data[2*PIX_W-1:PIX_W])
  );

  csc_mac #(
    .PIX_W(PIX_W), .FRAC_W(FRAC_W),
    .NEG0(1'b0), .NEG1(1'b1), .NEG2(1'b1), .OFFSET_EN(1'b1)
  ) u_mac_cr (
    .clk(clk), .rst_n(rst_n), .i_adv(w_adv),
    .i_x0(w_r), .i_x1(w_g), .i_x2(w_b),
    .i_k0(w_k[6]), .i_k1(w_k[7]), .i_k2(w_k[8]),
    .i_raw(w_b), .i_pass(w_pass),
    .o_dat(out_data[3*PIX_W-1:2*PIX_W])
  );

endmodule
